ui_input_controller: RTL and testbench

Conditions the pong station's raw front-panel I/O (active-low joystick up/down and arcade button) into clean, game-usable events. Each input is synchronized and debounced. Joystick holds become paddle-step pulses with an auto-repeat rate. Button presses latch into a sticky event until the game FSM clears them. The block also sequences the arcade button LED (off/on/blink). It sits between the top-level pins and the game/paddle logic.

---
 rtl/ui_input_controller_pkg.sv | 28 ++
 rtl/ui_input_controller_if.sv | 28 ++
 rtl/ui_input_controller_debouncer.sv | 58 +++++
 rtl/ui_input_controller.sv | 179 +++++++++++++++++
 tb/tb_ui_input_controller.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ui_input_controller_pkg.sv
// Shared types and default timing for the pong front-panel input controller.
// Imported by the interface, the debouncer and the top.
package ui_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_FAST  = 2'd3
    } led_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } joy_state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY    = 250000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 100000;
    localparam int unsigned DEF_BLINK_HALF      = 12500000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ui_input_controller_if.sv
// Front-panel pins plus the game-side control/event signals of the input controller.
// master = game/pin side driving inputs, slave = the controller.
interface ui_input_controller_if;
    import ui_pkg::*;

    logic      JOY_UP;
    logic      JOY_DOWN;
    logic      ARCADE_BUTTON;
    logic      ARCADE_LED;
    led_mode_t led_mode;
    logic      clear_inputs;
    logic      joystick_up;
    logic      joystick_down;
    logic      move_up;
    logic      move_down;
    logic      button_event;

    modport master (
        output JOY_UP, JOY_DOWN, ARCADE_BUTTON, led_mode, clear_inputs,
        input  ARCADE_LED, joystick_up, joystick_down, move_up, move_down, button_event
    );

    modport slave (
        input  JOY_UP, JOY_DOWN, ARCADE_BUTTON, led_mode, clear_inputs,
        output ARCADE_LED, joystick_up, joystick_down, move_up, move_down, button_event
    );

endinterface

// File: rtl/ui_input_controller_debouncer.sv
// Synchronizer + debouncer for one active-low raw pin; outputs the clean
// active-high level and a one-cycle pulse during the first cycle the level is high.
module input_debouncer
    import ui_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw_n,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   w_active;

    // Synchronizer idles at 1 (pin released)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw_n};
        end
    end

    assign w_active = ~r_sync[SYNC_STAGES-1];

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (w_active == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
                r_rise  <= ~r_level;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/ui_input_controller.sv
// Pong front-panel conditioner: debounced joystick/button, paddle step pulses
// with auto-repeat, sticky button event and arcade LED sequencing.
module ui_input_controller
    import ui_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned BLINK_HALF      = DEF_BLINK_HALF
) (
    input  logic                  clock,
    input  logic                  reset,
    ui_input_controller_if.slave  io_ui
);

    localparam int unsigned JOY_W     = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam int unsigned LED_W     = $clog2(BLINK_HALF + 1);
    localparam int unsigned FAST_HALF = ((BLINK_HALF / 4) == 0) ? 1 : (BLINK_HALF / 4);

    logic w_up;
    logic w_down;
    logic w_btn;
    logic w_btn_rise;
    logic w_unused_up_rise;
    logic w_unused_down_rise;

    input_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clock   (clock),
        .reset   (reset),
        .i_raw_n (io_ui.JOY_UP),
        .o_level (w_up),
        .o_rise  (w_unused_up_rise)
    );

    input_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clock   (clock),
        .reset   (reset),
        .i_raw_n (io_ui.JOY_DOWN),
        .o_level (w_down),
        .o_rise  (w_unused_down_rise)
    );

    input_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clock   (clock),
        .reset   (reset),
        .i_raw_n (io_ui.ARCADE_BUTTON),
        .o_level (w_btn),
        .o_rise  (w_btn_rise)
    );

    // Sticky button event; a fresh press beats a simultaneous clear
    logic r_button_event;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_button_event <= 1'b0;
        end else if (w_btn_rise) begin
            r_button_event <= 1'b1;
        end else if (io_ui.clear_inputs) begin
            r_button_event <= 1'b0;
        end
    end

    // Joystick step/auto-repeat FSM; both directions held counts as none
    joy_state_t       r_state, w_state_nxt;
    logic [JOY_W-1:0] r_joy_cnt, w_joy_cnt_nxt;
    logic             r_dir_up, w_dir_up_nxt;
    logic             r_move_up, w_move_up_nxt;
    logic             r_move_down, w_move_down_nxt;
    logic             w_dir_any;
    logic             w_dir_up;

    assign w_dir_any = w_up ^ w_down;
    assign w_dir_up  = w_up & ~w_down;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_joy_cnt   <= '0;
            r_dir_up    <= 1'b0;
            r_move_up   <= 1'b0;
            r_move_down <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_joy_cnt   <= w_joy_cnt_nxt;
            r_dir_up    <= w_dir_up_nxt;
            r_move_up   <= w_move_up_nxt;
            r_move_down <= w_move_down_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_joy_cnt_nxt   = r_joy_cnt;
        w_dir_up_nxt    = r_dir_up;
        w_move_up_nxt   = 1'b0;
        w_move_down_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dir_any) begin
                    w_move_up_nxt   = w_dir_up;
                    w_move_down_nxt = ~w_dir_up;
                    w_dir_up_nxt    = w_dir_up;
                    w_joy_cnt_nxt   = JOY_W'(REPEAT_DELAY);
                    w_state_nxt     = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!w_dir_any) begin
                    w_joy_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end else if (w_dir_up != r_dir_up) begin
                    w_move_up_nxt   = w_dir_up;
                    w_move_down_nxt = ~w_dir_up;
                    w_dir_up_nxt    = w_dir_up;
                    w_joy_cnt_nxt   = JOY_W'(REPEAT_DELAY);
                    w_state_nxt     = HOLD;
                end else if (r_joy_cnt <= JOY_W'(1)) begin
                    // Counter is about to reach zero: emit the repeat step now
                    w_move_up_nxt   = r_dir_up;
                    w_move_down_nxt = ~r_dir_up;
                    w_joy_cnt_nxt   = JOY_W'(REPEAT_PERIOD);
                    w_state_nxt     = REPEAT;
                end else begin
                    w_joy_cnt_nxt = r_joy_cnt - JOY_W'(1);
                end
            end
            default: begin
                w_joy_cnt_nxt = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // LED sequencer; any mode change restarts the blink phase with the LED lit
    led_mode_t        r_mode_q;
    logic [LED_W-1:0] r_led_cnt;
    logic             r_led;
    logic [LED_W-1:0] w_half_m1;

    assign w_half_m1 = (io_ui.led_mode == LED_FAST) ? LED_W'(FAST_HALF - 1)
                                                    : LED_W'(BLINK_HALF - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode_q  <= LED_OFF;
            r_led_cnt <= '0;
            r_led     <= 1'b0;
        end else begin
            r_mode_q <= io_ui.led_mode;
            if (io_ui.led_mode != r_mode_q) begin
                r_led_cnt <= '0;
                r_led     <= (io_ui.led_mode != LED_OFF);
            end else begin
                case (io_ui.led_mode)
                    LED_OFF: r_led <= 1'b0;
                    LED_ON:  r_led <= 1'b1;
                    default: begin
                        if (r_led_cnt == w_half_m1) begin
                            r_led_cnt <= '0;
                            r_led     <= ~r_led;
                        end else begin
                            r_led_cnt <= r_led_cnt + LED_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign io_ui.joystick_up   = w_up;
    assign io_ui.joystick_down = w_down;
    assign io_ui.move_up       = r_move_up;
    assign io_ui.move_down     = r_move_down;
    assign io_ui.button_event  = r_button_event;
    assign io_ui.ARCADE_LED    = r_led;

endmodule

// File: tb/tb_ui_input_controller.sv
// Directed bench for ui_input_controller with short timing parameters:
// button table, auto-repeat, reversal, LED patterns and asynchronous reset.
module tb_ui_input_controller;
    import ui_pkg::*;

    localparam int unsigned P_SYNC   = 2;
    localparam int unsigned P_DEB    = 4;
    localparam int unsigned P_DELAY  = 10;
    localparam int unsigned P_PERIOD = 5;
    localparam int unsigned P_BLINK  = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ui_input_controller_if u_if ();

    ui_input_controller #(
        .SYNC_STAGES     (P_SYNC),
        .DEBOUNCE_CYCLES (P_DEB),
        .REPEAT_DELAY    (P_DELAY),
        .REPEAT_PERIOD   (P_PERIOD),
        .BLINK_HALF      (P_BLINK)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io_ui (u_if)
    );

    typedef struct {
        logic btn;
        logic clr;
        logic be;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [5:0] mk(input logic ju, input logic jd, input logic mu,
                                      input logic md, input logic be, input logic led);
        return {ju, jd, mu, md, be, led};
    endfunction

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {u_if.joystick_up, u_if.joystick_down, u_if.move_up, u_if.move_down,
               u_if.button_event, u_if.ARCADE_LED};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: {ju,jd,mu,md,be,led} got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic b, input logic c, input logic e_be, input int n);
        vec_t v;
        v.btn = b;
        v.clr = c;
        v.be  = e_be;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic do_reset();
        u_if.JOY_UP        = 1'b1;
        u_if.JOY_DOWN      = 1'b1;
        u_if.ARCADE_BUTTON = 1'b1;
        u_if.clear_inputs  = 1'b0;
        u_if.led_mode      = LED_OFF;
        reset = 1'b1;
        step();
        check("reset_state", 6'b0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        // Button stimulus: {raw btn, clear_inputs, expected button_event}, one row per cycle
        add(1, 0, 0, 1);
        add(0, 0, 0, 3);   // 3-cycle glitch
        add(1, 0, 0, 5);
        add(0, 0, 0, 6);   // real press, debounced level rises on 6th edge
        add(0, 0, 1, 4);   // event one cycle later
        add(1, 0, 1, 6);   // release keeps the flag
        add(1, 1, 0, 1);
        add(1, 0, 0, 1);
        add(0, 0, 0, 6);   // second press
        add(0, 1, 1, 1);   // clear in the same cycle as the rise: set wins
        add(0, 1, 0, 1);   // clear on the next cycle, still held
        add(0, 0, 0, 2);
        add(1, 0, 0, 6);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            u_if.ARCADE_BUTTON = vecs[i].btn;
            u_if.clear_inputs  = vecs[i].clr;
            step();
            check($sformatf("button_v%0d", i), mk(0, 0, 0, 0, vecs[i].be, 0));
        end
        u_if.clear_inputs = 1'b0;

        // Auto-repeat: up held 40 cycles
        for (int e = 1; e <= 60; e++) begin
            logic exp_mu;
            u_if.JOY_UP = (e <= 40) ? 1'b0 : 1'b1;
            step();
            exp_mu = (e == 7) || (e >= 17 && e <= 42 && ((e - 17) % 5) == 0);
            check($sformatf("repeat_e%0d", e), mk(e >= 6 && e <= 45, 0, exp_mu, 0, 0, 0));
        end

        // Reversal: down joins while up repeats, then up is released
        for (int e = 1; e <= 50; e++) begin
            logic exp_mu;
            logic exp_md;
            u_if.JOY_UP   = (e <= 30) ? 1'b0 : 1'b1;
            u_if.JOY_DOWN = (e >= 21) ? 1'b0 : 1'b1;
            step();
            exp_mu = (e == 7) || (e == 17) || (e == 22);
            exp_md = (e == 37) || (e == 47);
            check($sformatf("reverse_e%0d", e),
                  mk(e >= 6 && e <= 35, e >= 26, exp_mu, exp_md, 0, 0));
        end

        do_reset();

        // LED: blink, off, fast, on
        for (int e = 1; e <= 21; e++) begin
            logic exp_led;
            if (e <= 12) begin
                u_if.led_mode = LED_BLINK;
                exp_led = (((e - 1) / 3) % 2) == 0;
            end else if (e == 13) begin
                u_if.led_mode = LED_OFF;
                exp_led = 1'b0;
            end else if (e <= 19) begin
                u_if.led_mode = LED_FAST;
                exp_led = ((e - 14) % 2) == 0;
            end else begin
                u_if.led_mode = LED_ON;
                exp_led = 1'b1;
            end
            step();
            check($sformatf("led_e%0d", e), mk(0, 0, 0, 0, 0, exp_led));
        end

        // Reset while up is held in REPEAT with the LED lit
        for (int e = 1; e <= 20; e++) begin
            u_if.JOY_UP = 1'b0;
            step();
            check($sformatf("pre_rst_e%0d", e), mk(e >= 6, 0, e == 7 || e == 17, 0, 0, 1));
        end
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 6'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("post_rst_e%0d", e), mk(e >= 6, 0, e == 7, 0, 0, 1));
        end
        u_if.JOY_UP = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
